// File: rtl/dpwm_comparador_if.sv
// Duty-command handshake between the DPWM controller and the comparator/output stage.
interface dpwm_duty_if;
    logic [10:0] duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic        duty_err;

    modport master (output duty_in, output duty_valid, input duty_ready, input duty_err);
    modport slave  (input duty_in, input duty_valid, output duty_ready, output duty_err);
endinterface

// File: rtl/dpwm_comparador.sv
// DPWM duty comparator with double-buffered duty command and registered PWM outputs.
// Optional dead-time insertion on pwm/pwm_l is enabled by defining DPWM_DEADTIME_EN.
module dpwm_comparador #(
    parameter int STEP = 50,
    parameter int MAX  = 1000
`ifdef DPWM_DEADTIME_EN
    ,
    parameter int DEAD = 2
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [9:0]        i_cuenta,
    dpwm_duty_if.slave        duty,
    output logic              o_pwm,
    output logic              o_pwm_l,
    output logic              o_period_start
);
    localparam logic [10:0] FULL = 11'(MAX + STEP);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    logic [10:0] r_duty_pend;
    logic [10:0] r_duty_act;
    logic        r_pend_v;
    logic        r_duty_ready;
    logic        r_duty_err;
    logic        r_period_start;

    logic        w_accept;
    logic        w_boundary;
    logic [10:0] w_duty_clamp;
    logic [10:0] w_duty_act_next;
    logic        w_pend_v_next;
    logic        w_run_next;
    logic        w_lt;

    assign w_accept        = duty.duty_valid && r_duty_ready;
    assign w_boundary      = (i_cuenta == 10'd0);
    assign w_duty_clamp    = (duty.duty_in > FULL) ? FULL : duty.duty_in;
    assign w_duty_act_next = (w_boundary && r_pend_v) ? r_duty_pend : r_duty_act;
    // Accept is only possible with the buffer empty, so accept and drain never collide.
    assign w_pend_v_next   = w_accept || (r_pend_v && !w_boundary);
    assign w_run_next      = (r_state == S_RUN) || w_boundary;
    // At a boundary cuenta is 0, so this also yields (0 < new duty_act).
    assign w_lt            = ({1'b0, i_cuenta} < w_duty_act_next);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_duty_pend    <= '0;
            r_duty_act     <= '0;
            r_pend_v       <= 1'b0;
            r_duty_ready   <= 1'b1;
            r_duty_err     <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_boundary) begin
                r_state <= S_RUN;
            end
            if (w_accept) begin
                r_duty_pend <= w_duty_clamp;
            end
            r_pend_v       <= w_pend_v_next;
            r_duty_ready   <= !w_pend_v_next;
            r_duty_act     <= w_duty_act_next;
            r_duty_err     <= w_accept && (duty.duty_in > FULL);
            r_period_start <= w_boundary;
        end
    end

    assign duty.duty_ready = r_duty_ready;
    assign duty.duty_err   = r_duty_err;
    assign o_period_start  = r_period_start;

`ifdef DPWM_DEADTIME_EN
    // Index 0 is the high side, index 1 the low side; each delays only its rising edge.
    logic [1:0] w_side_raw;
    logic [1:0] r_side_out;
    logic [3:0] r_dead_cnt [2];

    assign w_side_raw[0] = w_run_next && w_lt;
    assign w_side_raw[1] = w_run_next && !w_lt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dead
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_dead_cnt[gi] <= '0;
                    r_side_out[gi] <= 1'b0;
                end else if (!w_side_raw[gi]) begin
                    r_dead_cnt[gi] <= '0;
                    r_side_out[gi] <= 1'b0;
                end else if (r_dead_cnt[gi] == 4'(DEAD)) begin
                    r_side_out[gi] <= 1'b1;
                end else begin
                    r_dead_cnt[gi] <= r_dead_cnt[gi] + 4'd1;
                    r_side_out[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_pwm   = r_side_out[0];
    assign o_pwm_l = r_side_out[1];
`else
    logic r_pwm_raw;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pwm_raw <= 1'b0;
        end else begin
            r_pwm_raw <= w_run_next && w_lt;
        end
    end

    assign o_pwm   = r_pwm_raw;
    assign o_pwm_l = 1'b0;
`endif
endmodule
